// File: rtl/microcode_pkg.sv
// Shared encodings for the microcode sequencer: next-address controls, operand
// source selects, memory commands, fixed ROM field widths and sequencer states.
package microcode_pkg;

    localparam int unsigned ALU_OP_W  = 5;
    localparam int unsigned BUS_SEL_W = 5;
    localparam int unsigned MEM_CTL_W = 3;
    localparam int unsigned NAC_W     = 3;
    localparam int unsigned REG_SRC_W = 2;
    localparam int unsigned IMM_SEL_W = 2;

    // Dispatch lands on {opcode, 3'b000}; each opcode owns an 8-word slot
    localparam int unsigned DISPATCH_SHIFT = 3;
    localparam int unsigned FETCH_ADDR     = 0;

    // Next-address control
    typedef enum logic [NAC_W-1:0] {
        NAC_SEQ      = 3'd0,
        NAC_FETCH    = 3'd1,
        NAC_DISPATCH = 3'd2,
        NAC_BRZ      = 3'd3,
        NAC_WAITHIT  = 3'd4,
        NAC_HALT     = 3'd5
    } nac_e;

    // Register read-select source
    typedef enum logic [REG_SRC_W-1:0] {
        REG_SRC_FIX = 2'd0,
        REG_SRC_OP1 = 2'd1,
        REG_SRC_OP2 = 2'd2
    } reg_src_e;

    // Immediate source
    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_NONE    = 2'd0,
        IMM_OP2     = 2'd1,
        IMM_OP1_OP2 = 2'd2
    } imm_sel_e;

    // Memory commands
    localparam logic [MEM_CTL_W-1:0] MEM_IDLE  = 3'd0;
    localparam logic [MEM_CTL_W-1:0] MEM_FETCH = 3'd1;
    localparam logic [MEM_CTL_W-1:0] MEM_READ  = 3'd2;
    localparam logic [MEM_CTL_W-1:0] MEM_WRITE = 3'd4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Width-independent part of a ROM word; parametrised fields travel separately
    typedef struct packed {
        logic [ALU_OP_W-1:0]  alu_op;
        logic [BUS_SEL_W-1:0] bus_sel;
        logic [MEM_CTL_W-1:0] mem_ctl;
        nac_e                 nac;
        reg_src_e             reg_src;
        imm_sel_e             imm_sel;
        logic                 wr_dest;
    } ctl_t;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode ROM: micro-address -> control word.
// Any address not listed decodes as a HALT word with all fields zero.
module microcode_rom
    import microcode_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_SEL_W = 4,
    parameter int unsigned UADDR_W   = 9
) (
    input  logic [UADDR_W-1:0]   i_addr,
    output ctl_t                 o_ctl,
    output logic [NUM_REGS-1:0]  o_wr_mask,
    output logic [REG_SEL_W-1:0] o_reg_fix,
    output logic [UADDR_W-1:0]   o_target
);

    // Microprogram table
    always_comb begin
        o_ctl     = '{alu_op: '0, bus_sel: '0, mem_ctl: MEM_IDLE, nac: NAC_HALT,
                      reg_src: REG_SRC_FIX, imm_sel: IMM_NONE, wr_dest: 1'b0};
        o_wr_mask = '0;
        o_reg_fix = '0;
        o_target  = '0;
        case (i_addr)
            // FETCH: issue instruction fetch, wait for the memory
            UADDR_W'(9'h000): begin
                o_ctl.bus_sel = 5'd1;
                o_ctl.mem_ctl = MEM_FETCH;
                o_ctl.nac     = NAC_WAITHIT;
            end
            // Latch instruction register and dispatch on opcode
            UADDR_W'(9'h001): begin
                o_ctl.bus_sel = 5'd2;
                o_wr_mask     = NUM_REGS'(1);
                o_ctl.nac     = NAC_DISPATCH;
            end
            // opcode 1: halt (non-zero fields must not reach the outputs)
            UADDR_W'(9'h008): begin
                o_ctl.alu_op  = 5'd31;
                o_ctl.bus_sel = 5'd31;
                o_ctl.mem_ctl = MEM_READ;
                o_ctl.nac     = NAC_HALT;
            end
            // opcode 2: store op1 register with short immediate
            UADDR_W'(9'h010): begin
                o_ctl.alu_op  = 5'd2;
                o_ctl.mem_ctl = MEM_WRITE;
                o_ctl.reg_src = REG_SRC_OP1;
                o_ctl.imm_sel = IMM_OP2;
                o_ctl.nac     = NAC_SEQ;
            end
            UADDR_W'(9'h011): begin
                o_ctl.alu_op  = 5'd4;
                o_reg_fix     = REG_SEL_W'(10);
                o_ctl.nac     = NAC_FETCH;
            end
            // opcode 10: ALU op writing top register and op1 destination
            UADDR_W'(9'h050): begin
                o_ctl.alu_op  = 5'd3;
                o_ctl.bus_sel = 5'd3;
                o_wr_mask     = NUM_REGS'(1) << (NUM_REGS - 1);
                o_ctl.wr_dest = 1'b1;
                o_ctl.reg_src = REG_SRC_OP2;
                o_ctl.imm_sel = IMM_OP1_OP2;
                o_ctl.nac     = NAC_SEQ;
            end
            UADDR_W'(9'h051): begin
                o_ctl.alu_op  = 5'd1;
                o_ctl.nac     = NAC_BRZ;
                o_target      = UADDR_W'(9'h1F0);
            end
            UADDR_W'(9'h052): begin
                o_ctl.bus_sel = 5'd4;
                o_ctl.nac     = NAC_FETCH;
            end
            // Zero-path handler near the top of the space
            UADDR_W'(9'h1F0): begin
                o_ctl.alu_op  = 5'd6;
                o_ctl.nac     = NAC_BRZ;
                o_target      = UADDR_W'(9'h1FF);
            end
            // Last word: sequential step wraps back to FETCH
            UADDR_W'(9'h1FF): begin
                o_ctl.mem_ctl = MEM_READ;
                o_ctl.nac     = NAC_SEQ;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Microprogrammed control unit: micro-PC, next-address logic and registered
// control word. Optional wait timeout built when WAIT_TIMEOUT_EN is defined.
module microcode_sequencer
    import microcode_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_SEL_W = 4,
    parameter int unsigned UADDR_W   = 9,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned WAIT_MAX  = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [UADDR_W-DISPATCH_SHIFT-1:0] opcode,
    input  logic [REG_SEL_W-1:0]          operand1,
    input  logic [REG_SEL_W-1:0]          operand2,
    input  logic                          z_flag,
    input  logic                          mem_hit,
    output logic [ALU_OP_W-1:0]           alu_op,
    output logic [BUS_SEL_W-1:0]          bus_sel,
    output logic [NUM_REGS-1:0]           wr_en,
    output logic [REG_SEL_W-1:0]          reg_sel,
    output logic [MEM_CTL_W-1:0]          mem_ctl,
    output logic [IMM_W-1:0]              immediate,
    output logic [UADDR_W-1:0]            upc,
    output logic                          finished,
    output logic                          bus_err
);

    state_e               r_state;
    logic [UADDR_W-1:0]   r_upc;
    logic [ALU_OP_W-1:0]  r_alu_op;
    logic [BUS_SEL_W-1:0] r_bus_sel;
    logic [NUM_REGS-1:0]  r_wr_en;
    logic [REG_SEL_W-1:0] r_reg_sel;
    logic [MEM_CTL_W-1:0] r_mem_ctl;
    logic [IMM_W-1:0]     r_imm;
    logic                 r_finished;

    ctl_t                 w_ctl;
    logic [NUM_REGS-1:0]  w_wr_mask;
    logic [REG_SEL_W-1:0] w_reg_fix;
    logic [UADDR_W-1:0]   w_target;
    logic [NUM_REGS-1:0]  w_wr_en;
    logic [REG_SEL_W-1:0] w_reg_sel;
    logic [IMM_W-1:0]     w_imm;
    logic [UADDR_W-1:0]   w_upc_inc;
    logic [UADDR_W-1:0]   w_dispatch;

    microcode_rom #(
        .NUM_REGS  (NUM_REGS),
        .REG_SEL_W (REG_SEL_W),
        .UADDR_W   (UADDR_W)
    ) u_rom (
        .i_addr    (r_upc),
        .o_ctl     (w_ctl),
        .o_wr_mask (w_wr_mask),
        .o_reg_fix (w_reg_fix),
        .o_target  (w_target)
    );

    assign w_upc_inc  = r_upc + UADDR_W'(1);
    assign w_dispatch = {opcode, DISPATCH_SHIFT'(0)};

    // Decode the current ROM word against the instruction operand fields
    always_comb begin
        w_wr_en   = w_wr_mask | (w_ctl.wr_dest ? (NUM_REGS'(1) << operand1) : '0);
        w_reg_sel = w_reg_fix;
        w_imm     = '0;
        case (w_ctl.reg_src)
            REG_SRC_OP1: w_reg_sel = operand1;
            REG_SRC_OP2: w_reg_sel = operand2;
            default:     w_reg_sel = w_reg_fix;
        endcase
        case (w_ctl.imm_sel)
            IMM_OP2:     w_imm = IMM_W'(operand2);
            IMM_OP1_OP2: w_imm = IMM_W'({operand1, operand2});
            default:     w_imm = '0;
        endcase
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int unsigned WAIT_CNT_W = $clog2(WAIT_MAX + 1);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_inc;
    logic                  r_bus_err;

    assign w_wait_cnt_inc = r_wait_cnt + WAIT_CNT_W'(1);
    assign bus_err        = r_bus_err;
`else
    // No timeout in this build; WAIT_MAX only kept for a common parameter list
    assign bus_err = 1'b0 & (|WAIT_MAX);
`endif

    // Sequencer FSM, micro-PC and registered control word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_upc      <= UADDR_W'(FETCH_ADDR);
            r_alu_op   <= '0;
            r_bus_sel  <= '0;
            r_wr_en    <= '0;
            r_reg_sel  <= '0;
            r_mem_ctl  <= MEM_IDLE;
            r_imm      <= '0;
            r_finished <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
`endif
        end else if (en) begin
            case (r_state)
                ST_RUN: begin
                    if (w_ctl.nac == NAC_HALT) begin
                        r_alu_op   <= '0;
                        r_bus_sel  <= '0;
                        r_wr_en    <= '0;
                        r_reg_sel  <= '0;
                        r_mem_ctl  <= MEM_IDLE;
                        r_imm      <= '0;
                        r_finished <= 1'b1;
                        r_state    <= ST_HALTED;
                    end else begin
                        r_alu_op  <= w_ctl.alu_op;
                        r_bus_sel <= w_ctl.bus_sel;
                        r_wr_en   <= w_wr_en;
                        r_reg_sel <= w_reg_sel;
                        r_mem_ctl <= w_ctl.mem_ctl;
                        r_imm     <= w_imm;
                        case (w_ctl.nac)
                            NAC_SEQ:      r_upc <= w_upc_inc;
                            NAC_FETCH:    r_upc <= UADDR_W'(FETCH_ADDR);
                            NAC_DISPATCH: r_upc <= w_dispatch;
                            NAC_BRZ:      r_upc <= z_flag ? w_target : w_upc_inc;
                            NAC_WAITHIT: begin
                                if (mem_hit) begin
                                    r_upc <= w_upc_inc;
                                end else begin
                                    r_state <= ST_WAIT;
`ifdef WAIT_TIMEOUT_EN
                                    r_wait_cnt <= '0;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT: begin
                    // Outputs keep the WAITHIT word while stalled here
                    if (mem_hit) begin
                        r_upc   <= w_upc_inc;
                        r_state <= ST_RUN;
                    end
`ifdef WAIT_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= w_wait_cnt_inc;
                        if (32'(w_wait_cnt_inc) == WAIT_MAX) begin
                            r_alu_op   <= '0;
                            r_bus_sel  <= '0;
                            r_wr_en    <= '0;
                            r_reg_sel  <= '0;
                            r_mem_ctl  <= MEM_IDLE;
                            r_imm      <= '0;
                            r_bus_err  <= 1'b1;
                            r_finished <= 1'b1;
                            r_state    <= ST_HALTED;
                        end
                    end
`endif
                end
                ST_HALTED: ;
                default: r_state <= ST_HALTED;
            endcase
        end
    end

    assign alu_op    = r_alu_op;
    assign bus_sel   = r_bus_sel;
    assign wr_en     = r_wr_en;
    assign reg_sel   = r_reg_sel;
    assign mem_ctl   = r_mem_ctl;
    assign immediate = r_imm;
    assign upc       = r_upc;
    assign finished  = r_finished;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer. Each step pushes its expected
// registered outputs to a scoreboard, clocks once, then pops and compares.
// Timeout checks are compiled in when WAIT_TIMEOUT_EN is defined.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [5:0]  opcode;
    logic [3:0]  operand1;
    logic [3:0]  operand2;
    logic        z_flag;
    logic        mem_hit;
    logic [4:0]  alu_op;
    logic [4:0]  bus_sel;
    logic [15:0] wr_en;
    logic [3:0]  reg_sel;
    logic [2:0]  mem_ctl;
    logic [15:0] immediate;
    logic [8:0]  upc;
    logic        finished;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [8:0]  upc;
        logic [4:0]  alu;
        logic [4:0]  bus;
        logic [15:0] wr;
        logic [3:0]  rs;
        logic [2:0]  mem;
        logic [15:0] imm;
        logic        fin;
        logic        err;
    } exp_t;

    exp_t sb[$];

    microcode_sequencer #(
        .NUM_REGS  (16),
        .REG_SEL_W (4),
        .UADDR_W   (9),
        .IMM_W     (16),
        .WAIT_MAX  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .opcode    (opcode),
        .operand1  (operand1),
        .operand2  (operand2),
        .z_flag    (z_flag),
        .mem_hit   (mem_hit),
        .alu_op    (alu_op),
        .bus_sel   (bus_sel),
        .wr_en     (wr_en),
        .reg_sel   (reg_sel),
        .mem_ctl   (mem_ctl),
        .immediate (immediate),
        .upc       (upc),
        .finished  (finished),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the word at addr given current operands; -1 = all zero
    function automatic exp_t mk(input string tag, input int u, input int addr,
                                input logic fin, input logic err);
        exp_t e;
        e.tag = tag; e.upc = 9'(u); e.fin = fin; e.err = err;
        e.alu = '0; e.bus = '0; e.wr = '0; e.rs = '0; e.mem = '0; e.imm = '0;
        case (addr)
            'h000: begin e.bus = 5'd1; e.mem = 3'd1; end
            'h001: begin e.bus = 5'd2; e.wr = 16'h0001; end
            'h010: begin e.alu = 5'd2; e.mem = 3'd4; e.rs = operand1; e.imm = 16'(operand2); end
            'h011: begin e.alu = 5'd4; e.rs = 4'hA; end
            'h050: begin
                e.alu = 5'd3; e.bus = 5'd3;
                e.wr  = 16'h8000 | (16'h0001 << operand1);
                e.rs  = operand2;
                e.imm = 16'({operand1, operand2});
            end
            'h051: e.alu = 5'd1;
            'h052: e.bus = 5'd4;
            'h1F0: e.alu = 5'd6;
            'h1FF: e.mem = 3'd2;
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, queue expectation, compare after the edge
    task automatic cyc(input logic rst, input logic e, input logic mh, input logic zf,
                       input exp_t x);
        exp_t g;
        reset = rst; en = e; mem_hit = mh; z_flag = zf;
        sb.push_back(x);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({g.tag, ".upc"},      32'(upc),       32'(g.upc));
        chk({g.tag, ".alu_op"},   32'(alu_op),    32'(g.alu));
        chk({g.tag, ".bus_sel"},  32'(bus_sel),   32'(g.bus));
        chk({g.tag, ".wr_en"},    32'(wr_en),     32'(g.wr));
        chk({g.tag, ".reg_sel"},  32'(reg_sel),   32'(g.rs));
        chk({g.tag, ".mem_ctl"},  32'(mem_ctl),   32'(g.mem));
        chk({g.tag, ".imm"},      32'(immediate), 32'(g.imm));
        chk({g.tag, ".finished"}, 32'(finished),  32'(g.fin));
        chk({g.tag, ".bus_err"},  32'(bus_err),   32'(g.err));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mem_hit = 1'b0; z_flag = 1'b0;
        opcode = 6'b001010; operand1 = 4'd5; operand2 = 4'd9;

        cyc(1, 0, 0, 0, mk("reset0", 0, -1, 0, 0));
        cyc(1, 1, 1, 1, mk("reset1", 0, -1, 0, 0));

        // FETCH waits on mem_hit; fetch command held 4 cycles
        cyc(0, 1, 0, 0, mk("fetch_w1", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("fetch_w2", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("fetch_w3", 0, 'h000, 0, 0));
        cyc(0, 1, 1, 0, mk("fetch_hit", 1, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("dispatch", 'h050, 'h001, 0, 0));
        // op1=5 -> wr_en 8020, imm 59
        cyc(0, 1, 0, 0, mk("rom50_a", 'h051, 'h050, 0, 0));
        cyc(0, 1, 0, 1, mk("brz_taken", 'h1F0, 'h051, 0, 0));
        cyc(0, 1, 0, 0, mk("brz_fall", 'h1F1, 'h1F0, 0, 0));
        // unprogrammed word halts
        cyc(0, 1, 0, 0, mk("unprog_halt", 'h1F1, -1, 1, 0));
        cyc(0, 1, 1, 1, mk("halt_stuck", 'h1F1, -1, 1, 0));
        cyc(1, 1, 0, 0, mk("halt_reset", 0, -1, 0, 0));

        // Second pass with op1=3 -> imm 0039; BRZ not taken, then taken twice to 0x1FF
        operand1 = 4'd3;
        cyc(0, 1, 1, 0, mk("p2_fetch", 1, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("p2_disp", 'h050, 'h001, 0, 0));
        cyc(0, 1, 0, 0, mk("rom50_b", 'h051, 'h050, 0, 0));
        cyc(0, 1, 0, 0, mk("brz_nz", 'h052, 'h051, 0, 0));
        cyc(0, 1, 0, 0, mk("nac_fetch", 0, 'h052, 0, 0));
        cyc(0, 1, 1, 0, mk("p3_fetch", 1, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("p3_disp", 'h050, 'h001, 0, 0));
        cyc(0, 1, 0, 0, mk("p3_rom50", 'h051, 'h050, 0, 0));
        cyc(0, 1, 0, 1, mk("p3_brz1", 'h1F0, 'h051, 0, 0));
        cyc(0, 1, 0, 1, mk("p3_brz2", 'h1FF, 'h1F0, 0, 0));
        cyc(0, 1, 0, 0, mk("seq_wrap", 0, 'h1FF, 0, 0));
        // en=0 freezes everything, z_flag/mem_hit ignored
        cyc(0, 0, 1, 1, mk("stall", 0, 'h1FF, 0, 0));

        // opcode 2: op1/op2 select paths
        opcode = 6'b000010; operand1 = 4'd5; operand2 = 4'd9;
        cyc(0, 1, 1, 0, mk("op2_fetch", 1, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("op2_disp", 'h010, 'h001, 0, 0));
        cyc(0, 1, 0, 0, mk("rom10", 'h011, 'h010, 0, 0));
        cyc(0, 1, 0, 0, mk("rom11", 0, 'h011, 0, 0));

        // opcode 1: explicit HALT word with non-zero fields
        opcode = 6'b000001;
        cyc(0, 1, 1, 0, mk("op1_fetch", 1, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("op1_disp", 'h008, 'h001, 0, 0));
        cyc(0, 1, 0, 0, mk("halt_word", 'h008, -1, 1, 0));
        cyc(0, 1, 1, 0, mk("halt_word_stuck", 'h008, -1, 1, 0));
        cyc(1, 0, 0, 0, mk("halt_word_reset", 0, -1, 0, 0));

`ifdef WAIT_TIMEOUT_EN
        // WAIT_MAX=4 with two stalled cycles in the middle
        cyc(0, 1, 0, 0, mk("to_enter", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("to_c1", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("to_c2", 0, 'h000, 0, 0));
        cyc(0, 0, 0, 0, mk("to_stall1", 0, 'h000, 0, 0));
        cyc(0, 0, 0, 0, mk("to_stall2", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("to_c3", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("to_err", 0, -1, 1, 1));
        cyc(0, 1, 1, 0, mk("to_err_stuck", 0, -1, 1, 1));
        cyc(1, 1, 0, 0, mk("to_reset", 0, -1, 0, 0));
        // reset mid-WAIT, then hit on the final cycle wins
        cyc(0, 1, 0, 0, mk("rw_enter", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("rw_c1", 0, 'h000, 0, 0));
        cyc(1, 1, 0, 0, mk("rw_reset", 0, -1, 0, 0));
        cyc(0, 1, 0, 0, mk("lw_enter", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("lw_c1", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("lw_c2", 0, 'h000, 0, 0));
        cyc(0, 1, 0, 0, mk("lw_c3", 0, 'h000, 0, 0));
        cyc(0, 1, 1, 0, mk("lw_hit_wins", 1, 'h000, 0, 0));
`else
        // Without the timeout, WAIT lasts indefinitely and bus_err stays 0
        cyc(0, 1, 0, 0, mk("nw_enter", 0, 'h000, 0, 0));
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, mk("nw_hold", 0, 'h000, 0, 0));
        cyc(0, 1, 1, 0, mk("nw_hit", 1, 'h000, 0, 0));
        cyc(1, 1, 0, 0, mk("nw_reset", 0, -1, 0, 0));
        cyc(0, 1, 0, 0, mk("rw_enter", 0, 'h000, 0, 0));
        cyc(1, 1, 0, 0, mk("rw_reset", 0, -1, 0, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
